// File: rtl/chess_fifo_pkg.sv
// Shared types and helpers for the FIFO push-side arbiters.
package chess_fifo_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Index width for n items; a single item still gets a 1-bit index.
    function automatic int idx_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/fifo_push_arbiter_rr_picker.sv
// Round-robin picker: first set request at or after the pointer, searching
// upward and wrapping at N-1. Purely combinational, reusable by other arbiters.
module rr_picker #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic         found_o,
    output logic [W-1:0] idx_o
);

    logic [N-1:0] rot;

    // Rotate the request mask so the pointer position lands on bit 0.
    always_comb begin
        rot = '0;
        for (int i = 0; i < N; i++) begin
            int src;
            src = i + int'(ptr_i);
            if (src > N - 1) begin
                src = src - N;
            end
            rot[i] = req_i[src];
        end
    end

    // Priority-encode the lowest rotated bit, then map it back to a real index.
    always_comb begin
        int off;
        found_o = 1'b0;
        idx_o   = '0;
        off     = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found_o = 1'b1;
                off     = i;
            end
        end
        off = off + int'(ptr_i);
        if (off > N - 1) begin
            off = off - N;
        end
        if (found_o) begin
            idx_o = W'(off);
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Shares one FIFO push port among N_REQ producers: round-robin grant with a
// burst lock that ends on the holder's last beat or after MAX_BURST beats.
module fifo_push_arbiter
    import chess_fifo_pkg::*;
#(
    parameter int N_BITS    = 64,
    parameter int N_REQ     = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_last,
    input  logic [N_REQ*N_BITS-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      fifo_push,
    output logic [N_BITS-1:0]         fifo_data,
    input  logic                      fifo_full,
    output logic                      grant_valid,
    output logic [idx_w(N_REQ)-1:0]   grant_id,
    output logic                      burst_cut
);

    localparam int IW = idx_w(N_REQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    arb_state_t        state_q, state_d;
    logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]     grant_id_q, grant_id_d;
    logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
    logic              burst_cut_q, burst_cut_d;

    logic              pick_found;
    logic [IW-1:0]     pick_idx;
    logic [N_BITS-1:0] data_arr [N_REQ];

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
            assign data_arr[gi] = req_data[gi*N_BITS +: N_BITS];
        end
    endgenerate

    rr_picker #(
        .N (N_REQ),
        .W (IW)
    ) u_picker (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Next-state and handshake: arbitrate in IDLE, stream the holder in BUSY.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_id_d  = grant_id_q;
        beat_cnt_d  = beat_cnt_q;
        burst_cut_d = 1'b0;
        req_ready   = '0;
        fifo_push   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_id_d = pick_idx;
                    beat_cnt_d = '0;
                    state_d    = BUSY;
                end
            end
            BUSY: begin
                req_ready[grant_id_q] = !fifo_full;
                fifo_push             = req_valid[grant_id_q] && !fifo_full;
                if (fifo_push) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (req_last[grant_id_q] || (beat_cnt_q == BW'(MAX_BURST - 1))) begin
                        state_d     = IDLE;
                        grant_id_d  = '0;
                        beat_cnt_d  = '0;
                        rr_ptr_d    = (grant_id_q == IW'(N_REQ - 1)) ? '0 : grant_id_q + 1'b1;
                        burst_cut_d = !req_last[grant_id_q];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Data mux: holder's slice while BUSY, pointer slice while IDLE, zero in reset.
    always_comb begin
        fifo_data = '0;
        if (!rst) begin
            fifo_data = (state_q == BUSY) ? data_arr[grant_id_q] : data_arr[rr_ptr_q];
        end
    end

    // State registers; reset drops any grant immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            grant_id_q  <= '0;
            beat_cnt_q  <= '0;
            burst_cut_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_id_q  <= grant_id_d;
            beat_cnt_q  <= beat_cnt_d;
            burst_cut_q <= burst_cut_d;
        end
    end

    assign grant_valid = (state_q == BUSY);
    assign grant_id    = grant_id_q;
    assign burst_cut   = burst_cut_q;

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Bench for fifo_push_arbiter: producer queues and a behavioural FIFO drive the
// block; scenario tasks check timing and a random run checks against a model.
module tb_fifo_push_arbiter;

    localparam int NB = 64;
    localparam int NR = 4;
    localparam int MB = 16;
    localparam int PD = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic [NR-1:0]     req_valid, req_last, req_ready;
    logic [NR*NB-1:0]  req_data;
    logic              fifo_push, fifo_full, grant_valid, burst_cut;
    logic [NB-1:0]     fifo_data;
    logic [1:0]        grant_id;

    fifo_push_arbiter #(.N_BITS(NB), .N_REQ(NR), .MAX_BURST(MB)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .fifo_push   (fifo_push),
        .fifo_data   (fifo_data),
        .fifo_full   (fifo_full),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .burst_cut   (burst_cut)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // Producer beat queues
    logic [NB-1:0] pdata [NR][PD];
    logic          plast [NR][PD];
    int            phead [NR];
    int            ptail [NR];
    logic [NR-1:0] en;

    // Behavioural FIFO
    logic [NB-1:0] fifo_q [$];
    int            depth = 1000;
    logic          pop_now = 1'b0;
    logic [NB-1:0] last_pop;

    // Per-cycle samples
    logic [NR-1:0]    s_valid, s_last, s_ready;
    logic [NR*NB-1:0] s_rdata;
    logic             s_push, s_full, s_gv, s_cut;
    logic [1:0]       s_gid;
    logic [NB-1:0]    s_data;

    task automatic clear_prod();
        for (int i = 0; i < NR; i++) begin
            phead[i] = 0;
            ptail[i] = 0;
        end
        en = '0;
    endtask

    task automatic load(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            pdata[i][ptail[i]] = {i[7:0], 8'(k), 16'h0, $urandom()};
            plast[i][ptail[i]] = (k == n - 1);
            ptail[i]++;
        end
    endtask

    function automatic bit prod_pending();
        for (int i = 0; i < NR; i++) if (phead[i] < ptail[i]) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: drive producers, sample mid-cycle, advance, update models.
    task automatic step();
        for (int i = 0; i < NR; i++) begin
            if (en[i] && phead[i] < ptail[i]) begin
                req_valid[i]          = 1'b1;
                req_last[i]           = plast[i][phead[i]];
                req_data[i*NB +: NB]  = pdata[i][phead[i]];
            end else begin
                req_valid[i] = 1'b0;
                req_last[i]  = 1'b0;
            end
        end
        #1;
        s_valid = req_valid;  s_last = req_last;  s_rdata = req_data;
        s_ready = req_ready;  s_push = fifo_push; s_data  = fifo_data;
        s_full  = fifo_full;  s_gv   = grant_valid; s_gid = grant_id;
        s_cut   = burst_cut;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) if (s_valid[i] && s_ready[i]) phead[i]++;
        if (pop_now && fifo_q.size() > 0) last_pop = fifo_q.pop_front();
        if (s_push) fifo_q.push_back(s_data);
        fifo_full = (fifo_q.size() >= depth);
    endtask

    task automatic do_reset();
        clear_prod();
        pop_now = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        fifo_q.delete();
        depth = 1000;
        fifo_full = 1'b0;
    endtask

    task automatic drain();
        int k;
        en = '1;
        for (k = 0; k < 300; k++) begin
            step();
            if (!prod_pending() && !grant_valid) break;
        end
        n_cmp++;
        if (k >= 300) begin
            n_fail++;
            $display("FAIL drain: still busy after %0d cycles, want idle", k);
        end
    endtask

    task automatic test_reset();
        clear_prod();
        for (int i = 0; i < NR; i++) load(i, 2);
        en = '1;
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            n_cmp++;
            if (s_gv !== 1'b0 || s_push !== 1'b0 || s_cut !== 1'b0 || s_ready !== 4'b0 ||
                s_gid !== 2'd0 || s_data !== '0) begin
                n_fail++;
                $display("FAIL reset c%0d: gv=%b push=%b cut=%b ready=%b gid=%0d data=%h, want all 0",
                         c, s_gv, s_push, s_cut, s_ready, s_gid, s_data);
            end
        end
        rst = 1'b0;
        clear_prod();
        fifo_q.delete();
    endtask

    task automatic test_single_burst();
        logic [NB-1:0] got;
        do_reset();
        load(0, 3);
        en = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            bit eb;
            eb = (k >= 1 && k <= 3);
            step();
            n_cmp++;
            if (s_gv !== eb || s_push !== eb || s_gid !== 2'd0 || s_ready !== (eb ? 4'b0001 : 4'b0000)) begin
                n_fail++;
                $display("FAIL single_burst c%0d: gv=%b push=%b gid=%0d ready=%b, want gv=push=%b gid=0",
                         k, s_gv, s_push, s_gid, s_ready, eb);
            end
        end
        n_cmp++;
        if (fifo_q.size() != 3) begin
            n_fail++;
            $display("FAIL single_burst fifo_count: got %0d want 3", fifo_q.size());
        end
        for (int k = 0; k < 3 && fifo_q.size() > 0; k++) begin
            got = fifo_q.pop_front();
            n_cmp++;
            if (got !== pdata[0][k]) begin
                n_fail++;
                $display("FAIL single_burst pop%0d: got %h want %h", k, got, pdata[0][k]);
            end
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < NR; i++) begin
            load(i, 1);
            load(i, 1);
        end
        en = '1;
        for (int k = 0; k < 10; k++) begin
            bit eb;
            int eid;
            eb  = (k % 2 == 1);
            eid = eb ? ((k - 1) / 2) % NR : 0;
            step();
            n_cmp++;
            if (s_gv !== eb || s_push !== eb || s_gid !== 2'(eid)) begin
                n_fail++;
                $display("FAIL round_robin c%0d: gv=%b push=%b gid=%0d, want gv=push=%b gid=%0d",
                         k, s_gv, s_push, s_gid, eb, eid);
            end
        end
        drain();
        fifo_q.delete();
    endtask

    task automatic test_max_burst(input bit with_r3);
        logic [NB-1:0] got;
        int cuts;
        do_reset();
        load(2, 20);
        if (with_r3) load(3, 1);
        en = '1;
        cuts = 0;
        for (int k = 0; k < 25; k++) begin
            bit eb, ecut;
            int eid;
            if (with_r3) begin
                eb  = (k >= 1 && k <= 16) || (k == 18) || (k >= 20 && k <= 23);
                eid = (k == 18) ? 3 : (eb ? 2 : 0);
            end else begin
                eb  = (k >= 1 && k <= 16) || (k >= 18 && k <= 21);
                eid = eb ? 2 : 0;
            end
            ecut = (k == 17);
            step();
            if (s_cut) cuts++;
            n_cmp++;
            if (s_gv !== eb || s_push !== eb || s_gid !== 2'(eid) || s_cut !== ecut) begin
                n_fail++;
                $display("FAIL max_burst(r3=%0b) c%0d: gv=%b push=%b gid=%0d cut=%b, want %b/%b/%0d/%b",
                         with_r3, k, s_gv, s_push, s_gid, s_cut, eb, eb, eid, ecut);
            end
        end
        n_cmp++;
        if (cuts != 1) begin
            n_fail++;
            $display("FAIL max_burst cut_count: got %0d want 1", cuts);
        end
        n_cmp++;
        if (fifo_q.size() != (with_r3 ? 21 : 20)) begin
            n_fail++;
            $display("FAIL max_burst fifo_count: got %0d want %0d", fifo_q.size(), with_r3 ? 21 : 20);
        end
        for (int k = 0; k < 20 && fifo_q.size() > 0; k++) begin
            if (with_r3 && k == 16 && fifo_q.size() > 0) begin
                got = fifo_q.pop_front();
                n_cmp++;
                if (got !== pdata[3][0]) begin
                    n_fail++;
                    $display("FAIL max_burst r3_beat: got %h want %h", got, pdata[3][0]);
                end
            end
            if (fifo_q.size() > 0) begin
                got = fifo_q.pop_front();
                n_cmp++;
                if (got !== pdata[2][k]) begin
                    n_fail++;
                    $display("FAIL max_burst r2_beat%0d: got %h want %h", k, got, pdata[2][k]);
                end
            end
        end
    endtask

    task automatic test_fifo_full();
        logic [NB-1:0] got;
        do_reset();
        depth = 8;
        load(1, 12);
        en = 4'b0010;
        for (int k = 0; k < 14; k++) begin
            bit ep, eg;
            pop_now = (k == 11);
            ep = (k >= 1 && k <= 8) || (k == 12);
            eg = (k >= 1);
            step();
            n_cmp++;
            if (s_push !== ep || s_ready !== (ep ? 4'b0010 : 4'b0000) || s_gv !== eg ||
                s_gid !== (eg ? 2'd1 : 2'd0)) begin
                n_fail++;
                $display("FAIL fifo_full c%0d: push=%b ready=%b gv=%b gid=%0d full=%b, want push=%b gv=%b",
                         k, s_push, s_ready, s_gv, s_gid, s_full, ep, eg);
            end
        end
        pop_now = 1'b0;
        n_cmp++;
        if (last_pop !== pdata[1][0]) begin
            n_fail++;
            $display("FAIL fifo_full first_pop: got %h want %h", last_pop, pdata[1][0]);
        end
        depth = 1000;
        fifo_full = 1'b0;
        drain();
        n_cmp++;
        if (fifo_q.size() != 11) begin
            n_fail++;
            $display("FAIL fifo_full fifo_count: got %0d want 11", fifo_q.size());
        end
        for (int k = 1; k < 12 && fifo_q.size() > 0; k++) begin
            got = fifo_q.pop_front();
            n_cmp++;
            if (got !== pdata[1][k]) begin
                n_fail++;
                $display("FAIL fifo_full seq%0d: got %h want %h", k, got, pdata[1][k]);
            end
        end
    endtask

    task automatic test_drop_valid();
        do_reset();
        load(1, 5);
        load(0, 1);
        en = 4'b0010;
        for (int k = 0; k < 11; k++) begin
            bit ep, eg;
            int eid;
            if (k == 1) en[0] = 1'b1;
            en[1] = !(k >= 3 && k <= 5);
            ep  = (k == 1) || (k == 2) || (k >= 6 && k <= 8) || (k == 10);
            eg  = (k >= 1 && k <= 8) || (k == 10);
            eid = (k >= 1 && k <= 8) ? 1 : 0;
            step();
            n_cmp++;
            if (s_push !== ep || s_gv !== eg || s_gid !== 2'(eid)) begin
                n_fail++;
                $display("FAIL drop_valid c%0d: push=%b gv=%b gid=%0d, want %b/%b/%0d",
                         k, s_push, s_gv, s_gid, ep, eg, eid);
            end
        end
        fifo_q.delete();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        load(2, 1);
        load(3, 5);
        en = 4'b1100;
        for (int k = 0; k < 5; k++) begin
            bit eb;
            int eid;
            if (k == 4) rst = 1'b1;
            eb  = (k == 1) || (k == 3);
            eid = (k == 1) ? 2 : ((k == 3) ? 3 : 0);
            step();
            n_cmp++;
            if (s_push !== eb || s_gv !== eb || s_gid !== 2'(eid) ||
                s_ready !== (eb ? (4'b0001 << eid) : 4'b0000)) begin
                n_fail++;
                $display("FAIL reset_mid c%0d: push=%b gv=%b gid=%0d ready=%b, want push=gv=%b gid=%0d",
                         k, s_push, s_gv, s_gid, s_ready, eb, eid);
            end
        end
        step();
        rst = 1'b0;
        n_cmp++;
        if (fifo_q.size() != 2) begin
            n_fail++;
            $display("FAIL reset_mid kept_beats: got %0d want 2", fifo_q.size());
        end
        clear_prod();
        load(1, 1);
        load(3, 1);
        en = 4'b1010;
        step();
        step();
        n_cmp++;
        if (s_gv !== 1'b1 || s_gid !== 2'd1) begin
            n_fail++;
            $display("FAIL reset_mid regrant: gv=%b gid=%0d, want gv=1 gid=1", s_gv, s_gid);
        end
        drain();
        fifo_q.delete();
    endtask

    // Random traffic against a rule-level model of who should hold the port.
    task automatic test_random();
        bit            m_busy, m_cut;
        int            m_id, m_ptr, m_beats;
        bit            exp_push;
        logic [NR-1:0] exp_ready;
        logic [NB-1:0] exp_data;
        do_reset();
        depth = $urandom_range(4, 12);
        m_busy = 0; m_cut = 0; m_id = 0; m_ptr = 0; m_beats = 0;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (phead[i] >= ptail[i]) begin
                    phead[i] = 0;
                    ptail[i] = 0;
                    if ($urandom_range(0, 3) == 0) load(i, $urandom_range(1, 20));
                end
                en[i] = ($urandom_range(0, 7) != 0);
            end
            pop_now = $urandom_range(0, 1);
            step();
            exp_push  = m_busy && s_valid[m_id] && !s_full;
            exp_ready = (m_busy && !s_full) ? (4'b0001 << m_id) : 4'b0000;
            exp_data  = s_rdata[m_id*NB +: NB];
            n_cmp++;
            if (s_gv !== m_busy || s_gid !== (m_busy ? 2'(m_id) : 2'd0) || s_push !== exp_push ||
                s_ready !== exp_ready || s_cut !== m_cut || (exp_push && s_data !== exp_data)) begin
                n_fail++;
                $display("FAIL random c%0d: gv=%b gid=%0d push=%b ready=%b cut=%b data=%h, want %b/%0d/%b/%b/%b/%h",
                         c, s_gv, s_gid, s_push, s_ready, s_cut, s_data,
                         m_busy, m_busy ? m_id : 0, exp_push, exp_ready, m_cut, exp_data);
            end
            m_cut = 0;
            if (!m_busy) begin
                if (s_valid != 0) begin
                    for (int k = NR - 1; k >= 0; k--) begin
                        if (s_valid[(m_ptr + k) % NR]) m_id = (m_ptr + k) % NR;
                    end
                    m_busy  = 1;
                    m_beats = 0;
                end
            end else if (exp_push) begin
                m_beats++;
                if (s_last[m_id] || m_beats == MB) begin
                    m_busy = 0;
                    m_ptr  = (m_id + 1) % NR;
                    m_cut  = !s_last[m_id];
                end
            end
        end
        pop_now = 1'b0;
        depth = 1000;
        fifo_full = 1'b0;
        drain();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        fifo_full = 1'b0;
        en = '0;
        last_pop = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_max_burst(1'b1);
        test_max_burst(1'b0);
        test_fifo_full();
        test_drop_valid();
        test_reset_mid_burst();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_push_arbiter.md
Name: fifo_push_arbiter

Overview:
- Shares the single push port of one FIFO instance (move/event queue) between N_REQ producer units, e.g. per-piece move generators.
- Round-robin arbitration with burst lock: once granted, a requester keeps the port until it marks its last beat or hits MAX_BURST.
- Sits between the producers and the FIFO. The FIFO's pop side belongs to the consumer and is untouched.

Parameters:
- N_BITS, 64, data word width; matches the FIFO N_BITS.
- N_REQ, 4, number of requesters (2..16).
- MAX_BURST, 16, maximum beats per grant before forced release (>=1).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester data valid.
- req_last  in  N_REQ  per-requester last-beat-of-burst flag; qualified by req_valid.
- req_data  in  N_REQ*N_BITS  packed data; requester i occupies bits [i*N_BITS +: N_BITS].
- req_ready  out  N_REQ  per-requester accept; one-hot or zero.
- fifo_push  out  1  push strobe to the FIFO.
- fifo_data  out  N_BITS  data to the FIFO data_in.
- fifo_full  in  1  FIFO full flag.
- grant_valid  out  1  a requester currently holds the port.
- grant_id  out  $clog2(N_REQ)  index of the holder; 0 when grant_valid=0.
- burst_cut  out  1  one-cycle pulse when a burst is force-released at MAX_BURST without req_last.

Behaviour:
- Reset (asynchronous, while rst=1):
  - state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0.
  - grant_valid=0, req_ready=0, fifo_push=0, burst_cut=0, fifo_data=0.
  - A reset mid-burst drops the grant immediately. No push is issued in the reset cycle. The partial burst already in the FIFO is not retracted.
- State machine: IDLE, BUSY.
- IDLE:
  - req_ready=0 and fifo_push=0.
  - If any req_valid is set, pick the first set bit at or after rr_ptr, searching upward modulo N_REQ.
  - Register it into grant_id, set grant_valid=1, beat_cnt=0, and go to BUSY on the next edge.
  - Arbitration latency is 1 cycle from valid to grant.
- BUSY:
  - req_ready[grant_id] = !fifo_full; all other ready bits are 0.
  - fifo_push = req_valid[grant_id] && !fifo_full, combinational.
  - fifo_data = req_data slice of grant_id, also driven combinationally in IDLE from the rr_ptr slice; content is don't-care when fifo_push=0.
  - A transfer is a cycle with fifo_push=1. Each transfer increments beat_cnt.
- Release: on a transfer with req_last[grant_id]=1 OR beat_cnt==MAX_BURST-1:
  - go to IDLE, grant_valid=0, rr_ptr=(grant_id+1) mod N_REQ.
  - burst_cut=1 for one cycle, registered, if the release was forced and req_last=0.
- The granted requester dropping req_valid mid-burst is legal. The lock holds, no push is issued, beat_cnt is unchanged, and there is no timeout.
- fifo_full stalls: the grant holds, req_ready=0, and no beat is lost. The FIFO is never pushed while full, so its push&&pop overwrite path is never exercised from this block.
- A requester's req_data/req_last must stay stable while req_valid=1 && req_ready=0.
- Fairness: after release there is at least 1 IDLE cycle. No requester is granted twice while another has req_valid continuously high.
- Widths:
  - beat_cnt is $clog2(MAX_BURST+1) bits.
  - rr_ptr and grant_id are $clog2(N_REQ) bits; N_REQ=1 is clamped to 1-bit indices.
  - The wrap is an explicit compare to N_REQ-1, not a power-of-2 mask.

Decomposition:
- Shared package chess_fifo_pkg holds:
  - arb_state_t enum {IDLE, BUSY};
  - function idx_w(n) returning max(1,$clog2(n)).
- One combinational sub-module rr_picker (inputs: req mask, pointer; outputs: found, index) implements rotate, priority-encode and unrotate. It is reusable by other arbiters.

Test Plan:
- Reset, then req_valid=4'b0001 with a 3-beat burst (last on beat 3), fifo_full=0:
  - grant_id=0 one cycle after valid;
  - fifo_push high for 3 consecutive cycles;
  - FIFO pops D0, D1, D2 in order;
  - grant_valid=0 after beat 3.
- req_valid=4'b1111 held, every burst 1 beat:
  - grant order 0,1,2,3,0;
  - each grant is 2 cycles apart (1 IDLE + 1 BUSY).
- MAX_BURST=16, requester 2 streams 20 beats with req_last only on beat 20:
  - release after 16 pushes with burst_cut pulsed once;
  - next grant goes to requester 3 if valid, else requester 2 is re-granted for the remaining 4 beats.
- Fill the FIFO (N_SIZE=8) so fifo_full=1 during a burst:
  - req_ready=0 and fifo_push=0 while full;
  - after one consumer pop, exactly one beat is pushed;
  - the beat sequence in the FIFO is unbroken.
- Granted requester 1 drops req_valid for 3 cycles mid-burst while requester 0 is valid:
  - no push and grant_id stays 1;
  - requester 1 resumes and completes;
  - requester 0 is granted next.
- Assert rst during beat 2 of a burst:
  - same-cycle fifo_push=0, req_ready=0, grant_valid=0;
  - after deassert, arbitration restarts from rr_ptr=0.
